sgm_path_sequencer: RTL
=======================

SGM_PATH_SEQUENCER -- requirements
Module: sgm_path_sequencer

Interface
REQ-001 Parameter IMG_WIDTH, default 1600: active pixels per line; equals PATH_DELAY of the downstream path-cost datapath.
REQ-002 Parameter IMG_HEIGHT, default 720: active lines per frame.
REQ-003 Parameter P_BITS, default 8: width of penalties P1/P2.
REQ-004 in_clk  input  1  single clock; all logic rising-edge.
REQ-005 in_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_vsync  input  1  one-cycle frame-start pulse, before first in_de of a frame.
REQ-007 in_de  input  1  active-pixel strobe; cost array valid when high.
REQ-008 in_cfg_valid / out_cfg_ready  input/output  1/1  penalty-update handshake.
REQ-009 in_cfg_P1, in_cfg_P2  input  P_BITS each  requested penalties.
REQ-010 out_de  output  1  in_de delayed 1 cycle, gated to in-frame pixels.
REQ-011 out_path_beginning_h / _v / _d  output  1 each  path restart for horizontal (col 0), vertical (row 0), diagonal (col 0 or row 0) paths.
REQ-012 out_P1, out_P2  output  P_BITS each  penalties in force for current frame.
REQ-013 out_col, out_row  output  clog2(IMG_WIDTH), clog2(IMG_HEIGHT)  position of pixel on out_de.
REQ-014 out_L_valid  output  1  path-cost output valid (out_de delayed 1 cycle).
REQ-015 out_frame_done  output  1  one-cycle pulse after last pixel of frame.
REQ-016 out_line_err, out_frame_err  output  1 each  sticky-per-frame error flags.

Function
REQ-017 FSM states IDLE, ACTIVE, DONE; reset state IDLE.
REQ-018 IDLE->ACTIVE on in_vsync; col=0, row=0, pending config copied to out_P1/out_P2, error flags cleared.
REQ-019 ACTIVE: each in_de cycle yields out_de=1 next cycle with out_col/out_row of that pixel; col increments, saturating at IMG_WIDTH.
REQ-020 out_path_beginning_h=1 with out_de iff out_col==0; _v iff out_row==0; _d iff either; all 0 when out_de=0.
REQ-021 Line end = in_de falling edge: if col!=IMG_WIDTH set out_line_err; col<=0, row increments.
REQ-022 Pixels beyond col IMG_WIDTH-1 within a line: out_de suppressed, out_line_err set.
REQ-023 When row reaches IMG_HEIGHT: ACTIVE->DONE; DONE pulses out_frame_done one cycle, then ->IDLE.
REQ-024 in_de in IDLE or DONE: ignored (out_de=0), out_frame_err set.
REQ-025 in_vsync while ACTIVE: frame aborted and restarted as REQ-018 with pending config applied, then out_frame_err set (survives the clear); no out_frame_done.
REQ-026 Config: one-deep pending register; out_cfg_ready = !pending_full; transfer on valid&ready; pending applied only at REQ-018 frame start, never mid-frame.
REQ-027 Transfer in same cycle as in_vsync in IDLE: the new values apply to that frame.
REQ-028 out_L_valid = out_de registered once (matches one-register path-cost latency).
REQ-029 Penalties not range-checked; P1>P2 accepted as given.

Reset
REQ-030 Asserting in_rst_n low at any time, including mid-frame, forces IDLE immediately.
REQ-031 Reset values: all 1-bit outputs 0 except out_cfg_ready=1; counters 0; out_P1=8'd10, out_P2=8'd120 (truncated to P_BITS); pending empty.
REQ-032 After release, first action is wait for in_vsync; no partial frame resumes.

Structure
REQ-033 Shared package/include sgm_params: P_BITS, default penalties, FSM state encodings, clog2 function.
REQ-034 One sub-module line_position_counter: col/row counters with saturation and line-end detection.
REQ-035 All outputs registered; no combinational in->out path except out_cfg_ready.

Verification (IMG_WIDTH=8, IMG_HEIGHT=4)
REQ-036 Reset, vsync, 4 lines of 8-cycle de with 3-cycle gaps -> 32 out_de, _h on cols 0, _v on row 0 (8 pulses), _d 11 pulses, out_frame_done once, no errors.
REQ-037 cfg P1=5,P2=60 accepted mid-frame -> out_P1/out_P2 stay 10/120 until next vsync, then 5/60; out_cfg_ready low while pending.
REQ-038 Line 2 of 7 pixels -> out_line_err=1 through frame end, cleared by next vsync; row still advances.
REQ-039 Line of 10 pixels -> only 8 out_de, out_line_err=1.
REQ-040 vsync after row 1 -> counters restart at 0,0, out_frame_err=1, no out_frame_done for aborted frame.
REQ-041 in_rst_n low at row 2 col 3 -> outputs to reset values next edge; de without vsync afterwards -> out_de stays 0, out_frame_err=1.

Source files
------------

// File: rtl/sgm_params.sv
// ---------------------------------------------------------------------------
// sgm_params
// Shared definitions for the SGM path sequencer and its sub-blocks:
//   SGM_P_BITS   default penalty width
//   SGM_DEF_P1   penalty P1 in force after reset
//   SGM_DEF_P2   penalty P2 in force after reset
//   seq_state_t  frame sequencer FSM encoding
//   sgm_clog2    ceiling log2, never smaller than 1 so a bus of that
//                width always exists even for degenerate sizes
// ---------------------------------------------------------------------------
package sgm_params;

   localparam int SGM_P_BITS = 8;
   localparam int SGM_DEF_P1 = 10;
   localparam int SGM_DEF_P2 = 120;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } seq_state_t;

   function automatic int sgm_clog2(input int value);
      int result = 1;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/line_position_counter.sv
// ---------------------------------------------------------------------------
// line_position_counter
// Column/row position tracking for one frame of pixels.
// Ports:
//   in_clk, in_rst_n  clock, asynchronous active-low reset
//   clear             frame start: counters back to 0,0
//   enable            frame in progress (sequencer ACTIVE)
//   de                active-pixel strobe of the current cycle
//   pos_col, pos_row  position of the pixel presented on de this cycle
//   pix_valid         de on a column inside the line
//   overflow          de on a column beyond the last one of the line
//   line_end          falling edge of de (line finished)
//   short_line        line finished before reaching the full width
//   last_line         current row is the final row of the frame
// ---------------------------------------------------------------------------
module line_position_counter
   import sgm_params::*;
#(
   parameter int IMG_WIDTH  = 1600,
   parameter int IMG_HEIGHT = 720,
   localparam int COL_W     = sgm_clog2(IMG_WIDTH),
   localparam int ROW_W     = sgm_clog2(IMG_HEIGHT)
)(
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic             de,
   output logic [COL_W-1:0] pos_col,
   output logic [ROW_W-1:0] pos_row,
   output logic             pix_valid,
   output logic             overflow,
   output logic             line_end,
   output logic             short_line,
   output logic             last_line
);

   // Counters are one bit wider than the positions they report when needed,
   // so they can hold the saturation values IMG_WIDTH / IMG_HEIGHT.
   localparam int CNT_COL_W = sgm_clog2(IMG_WIDTH + 1);
   localparam int CNT_ROW_W = sgm_clog2(IMG_HEIGHT + 1);

   localparam logic [CNT_COL_W-1:0] COL_END  = CNT_COL_W'(IMG_WIDTH);
   localparam logic [CNT_ROW_W-1:0] ROW_END  = CNT_ROW_W'(IMG_HEIGHT);
   localparam logic [CNT_ROW_W-1:0] ROW_LAST = CNT_ROW_W'(IMG_HEIGHT - 1);

   logic [CNT_COL_W-1:0] col;
   logic [CNT_ROW_W-1:0] row;
   logic                 de_prev;

   // Decode what the current cycle means for the line: a real pixel, an
   // excess pixel past the line width, or the end of the line. A line that
   // ends with col short of IMG_WIDTH is reported as short.
   always_comb begin
      pos_col    = col[COL_W-1:0];
      pos_row    = row[ROW_W-1:0];
      pix_valid  = enable && de && (col != COL_END);
      overflow   = enable && de && (col == COL_END);
      line_end   = enable && de_prev && !de;
      short_line = line_end && (col != COL_END);
      last_line  = (row == ROW_LAST);
   end

   // Position counters. The column saturates at IMG_WIDTH so excess pixels
   // keep being flagged as overflow; the row saturates at IMG_HEIGHT. The
   // previous-de register is forced low outside a frame so that a strobe
   // seen while idle never fakes a line end once a frame starts.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         col     <= '0;
         row     <= '0;
         de_prev <= 1'b0;
      end else if (clear) begin
         col     <= '0;
         row     <= '0;
         de_prev <= 1'b0;
      end else if (enable) begin
         de_prev <= de;
         if (line_end) begin
            col <= '0;
            if (row != ROW_END) begin
               row <= row + 1'b1;
            end
         end else if (de && (col != COL_END)) begin
            col <= col + 1'b1;
         end
      end else begin
         de_prev <= 1'b0;
      end
   end

endmodule

// File: rtl/sgm_path_sequencer.sv
// ---------------------------------------------------------------------------
// sgm_path_sequencer
// Frame sequencer for the SGM path-cost datapath: tracks pixel position,
// marks path restarts, holds the per-frame penalties and flags framing
// errors.
// Ports:
//   in_clk, in_rst_n                   clock, asynchronous active-low reset
//   in_vsync                           one-cycle frame-start pulse
//   in_de                              active-pixel strobe
//   in_cfg_valid / out_cfg_ready       penalty-update handshake
//   in_cfg_P1, in_cfg_P2               requested penalties
//   out_de                             in_de delayed one cycle, in-frame only
//   out_path_beginning_h / _v / _d     path restart (col 0 / row 0 / either)
//   out_P1, out_P2                     penalties in force for this frame
//   out_col, out_row                   position of the pixel on out_de
//   out_L_valid                        out_de delayed one cycle
//   out_frame_done                     one-cycle pulse after the last line
//   out_line_err, out_frame_err        error flags, sticky until frame start
// ---------------------------------------------------------------------------
module sgm_path_sequencer
   import sgm_params::*;
#(
   parameter int IMG_WIDTH  = 1600,
   parameter int IMG_HEIGHT = 720,
   parameter int P_BITS     = SGM_P_BITS,
   localparam int COL_W     = sgm_clog2(IMG_WIDTH),
   localparam int ROW_W     = sgm_clog2(IMG_HEIGHT)
)(
   input  logic              in_clk,
   input  logic              in_rst_n,
   input  logic              in_vsync,
   input  logic              in_de,
   input  logic              in_cfg_valid,
   output logic              out_cfg_ready,
   input  logic [P_BITS-1:0] in_cfg_P1,
   input  logic [P_BITS-1:0] in_cfg_P2,
   output logic              out_de,
   output logic              out_path_beginning_h,
   output logic              out_path_beginning_v,
   output logic              out_path_beginning_d,
   output logic [P_BITS-1:0] out_P1,
   output logic [P_BITS-1:0] out_P2,
   output logic [COL_W-1:0]  out_col,
   output logic [ROW_W-1:0]  out_row,
   output logic              out_L_valid,
   output logic              out_frame_done,
   output logic              out_line_err,
   output logic              out_frame_err
);

   localparam logic [P_BITS-1:0] RST_P1 = P_BITS'(SGM_DEF_P1);
   localparam logic [P_BITS-1:0] RST_P2 = P_BITS'(SGM_DEF_P2);

   seq_state_t        state;
   seq_state_t        state_next;
   logic              counting;
   logic              cfg_xfer;
   logic              pending_full;
   logic [P_BITS-1:0] pend_P1;
   logic [P_BITS-1:0] pend_P2;

   logic [COL_W-1:0]  pos_col;
   logic [ROW_W-1:0]  pos_row;
   logic              pix_valid;
   logic              overflow;
   logic              line_end;
   logic              short_line;
   logic              last_line;

   line_position_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT)
   ) u_position (
      .in_clk     (in_clk),
      .in_rst_n   (in_rst_n),
      .clear      (in_vsync),
      .enable     (counting),
      .de         (in_de),
      .pos_col    (pos_col),
      .pos_row    (pos_row),
      .pix_valid  (pix_valid),
      .overflow   (overflow),
      .line_end   (line_end),
      .short_line (short_line),
      .last_line  (last_line)
   );

   assign out_cfg_ready = !pending_full;

   // FSM state register.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A vsync always (re)starts a frame: from IDLE, as an
   // abort of a frame in progress, and also in the single DONE cycle so a
   // back-to-back frame start is not lost (the done pulse still fires).
   // The frame ends on the falling edge of de on the last row.
   always_comb begin
      state_next = state;
      counting   = (state == ACTIVE);
      cfg_xfer   = in_cfg_valid && out_cfg_ready;
      case (state)
         IDLE: begin
            if (in_vsync) begin
               state_next = ACTIVE;
            end
         end
         ACTIVE: begin
            if (in_vsync) begin
               state_next = ACTIVE;
            end else if (line_end && last_line) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = in_vsync ? ACTIVE : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Penalty configuration. One update can wait in the pending register;
   // it only reaches out_P1/out_P2 at a frame start so a frame is never
   // processed with mixed penalties. An update accepted in the vsync cycle
   // itself bypasses the pending register and applies to the new frame.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         pending_full <= 1'b0;
         pend_P1      <= RST_P1;
         pend_P2      <= RST_P2;
         out_P1       <= RST_P1;
         out_P2       <= RST_P2;
      end else if (in_vsync) begin
         if (cfg_xfer) begin
            out_P1 <= in_cfg_P1;
            out_P2 <= in_cfg_P2;
         end else if (pending_full) begin
            out_P1       <= pend_P1;
            out_P2       <= pend_P2;
            pending_full <= 1'b0;
         end
      end else if (cfg_xfer) begin
         pend_P1      <= in_cfg_P1;
         pend_P2      <= in_cfg_P2;
         pending_full <= 1'b1;
      end
   end

   // Pixel outputs and error flags. Every output is a register. A frame
   // start clears the error flags, except that aborting a running frame
   // leaves out_frame_err set for the restarted frame. Strobes outside a
   // frame are dropped and reported through out_frame_err.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_de               <= 1'b0;
         out_path_beginning_h <= 1'b0;
         out_path_beginning_v <= 1'b0;
         out_path_beginning_d <= 1'b0;
         out_col              <= '0;
         out_row              <= '0;
         out_L_valid          <= 1'b0;
         out_frame_done       <= 1'b0;
         out_line_err         <= 1'b0;
         out_frame_err        <= 1'b0;
      end else begin
         out_L_valid          <= out_de;
         out_frame_done       <= (state == DONE);
         out_de               <= 1'b0;
         out_path_beginning_h <= 1'b0;
         out_path_beginning_v <= 1'b0;
         out_path_beginning_d <= 1'b0;
         if (in_vsync) begin
            out_line_err  <= 1'b0;
            out_frame_err <= (state == ACTIVE);
         end else if (state == ACTIVE) begin
            if (pix_valid) begin
               out_de               <= 1'b1;
               out_col              <= pos_col;
               out_row              <= pos_row;
               out_path_beginning_h <= (pos_col == '0);
               out_path_beginning_v <= (pos_row == '0);
               out_path_beginning_d <= (pos_col == '0) || (pos_row == '0);
            end
            if (overflow || short_line) begin
               out_line_err <= 1'b1;
            end
         end else if (in_de) begin
            out_frame_err <= 1'b1;
         end
      end
   end

endmodule
